// File: rtl/onchip_ram_pkg.sv
// Shared definitions for the dual-port on-chip RAM: default sizes, the
// byte-lane merge helper and the read request descriptor.
package onchip_ram_pkg;

    localparam int ONCHIP_RAM_DATA_W_DEF = 32;
    localparam int ONCHIP_RAM_DEPTH_DEF  = 32000;

    // Widest word be_merge can handle; callers zero-extend and truncate.
    localparam int ONCHIP_RAM_MAX_W  = 256;
    localparam int ONCHIP_RAM_MAX_BE = ONCHIP_RAM_MAX_W / 8;

    // One read request travelling down a port's read pipeline.
    typedef struct packed {
        logic valid;
        logic addr_oor;
    } rd_req_t;

    // Replace every byte of old_w whose be bit is set with the byte of new_w.
    function automatic logic [ONCHIP_RAM_MAX_W-1:0] be_merge(
        input logic [ONCHIP_RAM_MAX_W-1:0]  old_w,
        input logic [ONCHIP_RAM_MAX_W-1:0]  new_w,
        input logic [ONCHIP_RAM_MAX_BE-1:0] be
    );
        logic [ONCHIP_RAM_MAX_W-1:0] r;
        r = old_w;
        for (int i = 0; i < ONCHIP_RAM_MAX_BE; i++) begin
            if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/onchip_ram_rdpipe.sv
// Per-port read pipeline: tracks accepted reads, zeroes out-of-range
// results, holds everything while clken is low and optionally adds an output
// register. With ONCHIP_RAM_BYPASS_EN defined it also forwards a same-cycle
// write from the other port into the read result.
module onchip_ram_rdpipe
    import onchip_ram_pkg::*;
#(
    parameter int DATA_W  = ONCHIP_RAM_DATA_W_DEF,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clken,
    input  logic              req_accept,
    input  logic              req_oor,
    input  logic [DATA_W-1:0] ram_q,
`ifdef ONCHIP_RAM_BYPASS_EN
    input  logic              fwd_hit,
    input  logic [DATA_W-1:0] fwd_data,
    input  logic [DATA_W/8-1:0] fwd_be,
`endif
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);

    rd_req_t           req_d, req_q;
    logic              out_vld_d, out_vld_q;
    logic [DATA_W-1:0] out_data_d, out_data_q;
    logic [DATA_W-1:0] word;

`ifdef ONCHIP_RAM_BYPASS_EN
    logic                fwd_hit_d, fwd_hit_q;
    logic [DATA_W-1:0]   fwd_data_d, fwd_data_q;
    logic [DATA_W/8-1:0] fwd_be_d, fwd_be_q;

    // Capture the colliding write alongside the read it belongs to.
    always_comb begin
        fwd_hit_d  = fwd_hit_q;
        fwd_data_d = fwd_data_q;
        fwd_be_d   = fwd_be_q;
        if (clken) begin
            fwd_hit_d  = req_accept & fwd_hit;
            fwd_data_d = fwd_data;
            fwd_be_d   = fwd_be;
        end
    end

    // Forwarding registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
            fwd_be_q   <= '0;
        end else begin
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
            fwd_be_q   <= fwd_be_d;
        end
    end

    // RAM returned the old word; lay the other port's written bytes over it.
    always_comb begin
        word = ram_q;
        if (fwd_hit_q) begin
            word = DATA_W'(be_merge(ONCHIP_RAM_MAX_W'(ram_q),
                                    ONCHIP_RAM_MAX_W'(fwd_data_q),
                                    ONCHIP_RAM_MAX_BE'(fwd_be_q)));
        end
    end
`else
    // No forwarding: a cross-port collision returns the old word.
    always_comb word = ram_q;
`endif

    // Advance the request and first result stage only on enabled cycles;
    // data holds its last value when no result is produced.
    always_comb begin
        req_d      = req_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        if (clken) begin
            req_d.valid    = req_accept;
            req_d.addr_oor = req_oor;
            out_vld_d      = req_q.valid;
            if (req_q.valid) out_data_d = req_q.addr_oor ? '0 : word;
        end
    end

    // Request and first result stage registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            req_q      <= req_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic              vld2_d, vld2_q;
        logic [DATA_W-1:0] data2_d, data2_q;

        // Extra output stage, same hold rules as the first stage.
        always_comb begin
            vld2_d  = vld2_q;
            data2_d = data2_q;
            if (clken) begin
                vld2_d = out_vld_q;
                if (out_vld_q) data2_d = out_data_q;
            end
        end

        // Output stage registers.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld2_q  <= 1'b0;
                data2_q <= '0;
            end else begin
                vld2_q  <= vld2_d;
                data2_q <= data2_d;
            end
        end

        // A held result only counts once clken is back high.
        assign readdatavalid = vld2_q & clken;
        assign readdata      = data2_q;
    end else begin : g_no_out_reg
        assign readdatavalid = out_vld_q & clken;
        assign readdata      = out_data_q;
    end

endmodule

// File: rtl/onchip_ram_dualport.sv
// Dual-port on-chip RAM with two Avalon-MM slave ports on one clock.
// Optional build macro: ONCHIP_RAM_BYPASS_EN (cross-port write forwarding).
module onchip_ram_dualport
    import onchip_ram_pkg::*;
#(
    parameter int DATA_W  = ONCHIP_RAM_DATA_W_DEF,
    parameter int DEPTH   = ONCHIP_RAM_DEPTH_DEF,
    parameter int ADDR_W  = 15,
    parameter int OUT_REG = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clken,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] s1_ram_q, s2_ram_q;
    logic [IDX_W-1:0]  s1_idx, s2_idx;
    logic              s1_oor, s2_oor;
    logic              s1_rd_acc, s2_rd_acc;
    logic              s1_wr_en, s2_wr_en;

    assign s1_oor = (32'(s1_address) >= DEPTH);
    assign s2_oor = (32'(s2_address) >= DEPTH);
    assign s1_idx = s1_address[IDX_W-1:0];
    assign s2_idx = s2_address[IDX_W-1:0];

    // A write on the same port as a read discards the read.
    assign s1_rd_acc = clken & s1_chipselect & s1_read & ~s1_write;
    assign s2_rd_acc = clken & s2_chipselect & s2_read & ~s2_write;
    assign s1_wr_en  = clken & s1_chipselect & s1_write & ~s1_oor;
    assign s2_wr_en  = clken & s2_chipselect & s2_write & ~s2_oor;

    // Byte-lane writes; s1 is applied last so it wins on bytes both enable.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (s2_wr_en && s2_byteenable[b]) mem[s2_idx][b*8 +: 8] <= s2_writedata[b*8 +: 8];
            if (s1_wr_en && s1_byteenable[b]) mem[s1_idx][b*8 +: 8] <= s1_writedata[b*8 +: 8];
        end
    end

    // Synchronous RAM reads (old word on collision), held while clken is low.
    always_ff @(posedge clk) begin
        if (clken) begin
            s1_ram_q <= mem[s1_idx];
            s2_ram_q <= mem[s2_idx];
        end
    end

    onchip_ram_rdpipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_rdpipe_s1 (
        .clk           (clk),
        .reset_n       (reset_n),
        .clken         (clken),
        .req_accept    (s1_rd_acc),
        .req_oor       (s1_oor),
        .ram_q         (s1_ram_q),
`ifdef ONCHIP_RAM_BYPASS_EN
        .fwd_hit       (s2_wr_en && (s2_address == s1_address)),
        .fwd_data      (s2_writedata),
        .fwd_be        (s2_byteenable),
`endif
        .readdata      (s1_readdata),
        .readdatavalid (s1_readdatavalid)
    );

    onchip_ram_rdpipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_rdpipe_s2 (
        .clk           (clk),
        .reset_n       (reset_n),
        .clken         (clken),
        .req_accept    (s2_rd_acc),
        .req_oor       (s2_oor),
        .ram_q         (s2_ram_q),
`ifdef ONCHIP_RAM_BYPASS_EN
        .fwd_hit       (s1_wr_en && (s1_address == s2_address)),
        .fwd_data      (s1_writedata),
        .fwd_be        (s1_byteenable),
`endif
        .readdata      (s2_readdata),
        .readdatavalid (s2_readdatavalid)
    );

endmodule

// File: tb/tb_onchip_ram_dualport.sv
// Testbench for onchip_ram_dualport: directed scenarios plus randomized
// traffic against a word-array model with per-port expected queues.
module tb_onchip_ram_dualport;

    localparam int DW      = 32;
    localparam int DEPTH   = 1000;
    localparam int AW      = 10;
    localparam int OUT_REG = 0;
    localparam int LAT     = OUT_REG + 1;

    logic          clk, reset_n, clken;
    logic [AW-1:0] s1_address, s2_address;
    logic          s1_chipselect, s1_read, s1_write;
    logic          s2_chipselect, s2_read, s2_write;
    logic [3:0]    s1_byteenable, s2_byteenable;
    logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
    logic          s1_readdatavalid, s2_readdatavalid;

    int total = 0;
    int bad   = 0;
    int en_cnt = 0;

    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] exp1_q[$], exp2_q[$];
    int            due1_q[$], due2_q[$];
    logic [DW-1:0] got1_q[$], got2_q[$];

    onchip_ram_dualport #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .OUT_REG(OUT_REG)) dut (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count enabled edges; a read accepted at enabled edge A is due at A+LAT.
    always @(posedge clk) if (reset_n && clken) en_cnt++;

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            total++;
            if (due1_q.size() > 0 && due1_q[0] == en_cnt && clken) begin
                if (s1_readdatavalid !== 1'b1 || s1_readdata !== exp1_q[0]) begin
                    bad++;
                    $display("FAIL s1_read: got vld=%0b data=%h want vld=1 data=%h",
                             s1_readdatavalid, s1_readdata, exp1_q[0]);
                end
                void'(exp1_q.pop_front());
                void'(due1_q.pop_front());
            end else if (s1_readdatavalid !== 1'b0) begin
                bad++;
                $display("FAIL s1_unexpected_valid: got vld=%0b want 0", s1_readdatavalid);
            end
            total++;
            if (due2_q.size() > 0 && due2_q[0] == en_cnt && clken) begin
                if (s2_readdatavalid !== 1'b1 || s2_readdata !== exp2_q[0]) begin
                    bad++;
                    $display("FAIL s2_read: got vld=%0b data=%h want vld=1 data=%h",
                             s2_readdatavalid, s2_readdata, exp2_q[0]);
                end
                void'(exp2_q.pop_front());
                void'(due2_q.pop_front());
            end else if (s2_readdatavalid !== 1'b0) begin
                bad++;
                $display("FAIL s2_unexpected_valid: got vld=%0b want 0", s2_readdatavalid);
            end
            if (s1_readdatavalid === 1'b1) got1_q.push_back(s1_readdata);
            if (s2_readdatavalid === 1'b1) got2_q.push_back(s2_readdata);
        end
    end

    // ---------------- driver ----------------
    // Drive one cycle on both ports and update the model by the port rules.
    task automatic drive(input logic en,
                         input logic c1, input logic r1, input logic w1, input logic [AW-1:0] a1,
                         input logic [3:0] b1, input logic [DW-1:0] d1,
                         input logic c2, input logic r2, input logic w2, input logic [AW-1:0] a2,
                         input logic [3:0] b2, input logic [DW-1:0] d2);
        logic          acc_w1, acc_w2;
        logic [DW-1:0] e;
        clken = en;
        s1_chipselect = c1; s1_read = r1; s1_write = w1; s1_address = a1;
        s1_byteenable = b1; s1_writedata = d1;
        s2_chipselect = c2; s2_read = r2; s2_write = w2; s2_address = a2;
        s2_byteenable = b2; s2_writedata = d2;
        if (en && reset_n) begin
            acc_w1 = c1 && w1 && (int'(a1) < DEPTH);
            acc_w2 = c2 && w2 && (int'(a2) < DEPTH);
            if (c1 && r1 && !w1) begin
                e = (int'(a1) < DEPTH) ? mem_m[a1] : '0;
`ifdef ONCHIP_RAM_BYPASS_EN
                if (acc_w2 && a2 == a1)
                    for (int i = 0; i < 4; i++) if (b2[i]) e[i*8 +: 8] = d2[i*8 +: 8];
`endif
                exp1_q.push_back(e);
                due1_q.push_back(en_cnt + 1 + LAT);
            end
            if (c2 && r2 && !w2) begin
                e = (int'(a2) < DEPTH) ? mem_m[a2] : '0;
`ifdef ONCHIP_RAM_BYPASS_EN
                if (acc_w1 && a1 == a2)
                    for (int i = 0; i < 4; i++) if (b1[i]) e[i*8 +: 8] = d1[i*8 +: 8];
`endif
                exp2_q.push_back(e);
                due2_q.push_back(en_cnt + 1 + LAT);
            end
            for (int i = 0; i < 4; i++) begin
                if (acc_w2 && b2[i]) mem_m[a2][i*8 +: 8] = d2[i*8 +: 8];
                if (acc_w1 && b1[i]) mem_m[a1][i*8 +: 8] = d1[i*8 +: 8];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1, 0, 0, 0, '0, '0, '0, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] b);
        drive(1, 1, 0, 1, a, b, d, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic rd1(input logic [AW-1:0] a);
        drive(1, 1, 1, 0, a, '0, '0, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic rd2(input logic [AW-1:0] a);
        drive(1, 0, 0, 0, '0, '0, '0, 1, 1, 0, a, '0, '0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (s1_readdatavalid !== 1'b0 || s2_readdatavalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid: got s1=%0b s2=%0b want 0 0", s1_readdatavalid, s2_readdatavalid);
        end
        total++;
        if (s1_readdata !== '0 || s2_readdata !== '0) begin
            bad++;
            $display("FAIL reset_data: got s1=%h s2=%h want 0 0", s1_readdata, s2_readdata);
        end
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_preload;
        for (int a = 0; a < DEPTH / 2; a++)
            drive(1, 1, 0, 1, AW'(a), 4'hF, $urandom, 1, 0, 1, AW'(a + DEPTH / 2), 4'hF, $urandom);
        idle(1);
    endtask

    task automatic test_byte_mask;
        wr1(5, 32'hDEADBEEF, 4'b1111);
        wr1(5, 32'h00000011, 4'b0001);
        rd1(5);
        idle(LAT);
        total++;
        if (s1_readdatavalid !== 1'b1 || s1_readdata !== 32'hDEADBE11) begin
            bad++;
            $display("FAIL byte_mask: got vld=%0b data=%h want vld=1 data=deadbe11",
                     s1_readdatavalid, s1_readdata);
        end
        idle(2);
    endtask

    task automatic test_collision;
        wr1(9, 32'h0, 4'hF);
        drive(1, 1, 0, 1, 9, 4'b0011, 32'hAAAAAAAA, 1, 0, 1, 9, 4'b0110, 32'h55555555);
        rd2(9);
        idle(LAT);
        total++;
        if (s2_readdatavalid !== 1'b1 || s2_readdata !== 32'h0055AAAA) begin
            bad++;
            $display("FAIL collision: got vld=%0b data=%h want vld=1 data=0055aaaa",
                     s2_readdatavalid, s2_readdata);
        end
        idle(2);
    endtask

    task automatic test_cross_rdw;
        logic [DW-1:0] want;
`ifdef ONCHIP_RAM_BYPASS_EN
        want = 32'h2;
`else
        want = 32'h1;
`endif
        wr1(3, 32'h1, 4'hF);
        drive(1, 1, 0, 1, 3, 4'hF, 32'h2, 1, 1, 0, 3, '0, '0);
        idle(LAT);
        total++;
        if (s2_readdatavalid !== 1'b1 || s2_readdata !== want) begin
            bad++;
            $display("FAIL cross_rdw: got vld=%0b data=%h want vld=1 data=%h",
                     s2_readdatavalid, s2_readdata, want);
        end
        rd1(3);
        idle(LAT);
        total++;
        if (s1_readdata !== 32'h2) begin
            bad++;
            $display("FAIL cross_rdw_after: got %h want 00000002", s1_readdata);
        end
        idle(2);
    endtask

    task automatic test_clken;
        for (int i = 0; i < 8; i++) wr1(AW'(i), DW'(i), 4'hF);
        for (int pass = 0; pass < 2; pass++) begin
            got2_q.delete();
            for (int i = 0; i < 8; i++) begin
                if (pass == 1 && i == 4)
                    repeat (3) drive(0, 1, 0, 1, 7, 4'hF, 32'hBAD0BAD0, 1, 1, 0, 99, '0, '0);
                rd2(AW'(i));
            end
            idle(LAT + 2);
            total++;
            if (got2_q.size() != 8) begin
                bad++;
                $display("FAIL clken_count pass%0d: got %0d pulses want 8", pass, got2_q.size());
            end
            for (int i = 0; i < 8 && i < got2_q.size(); i++) begin
                total++;
                if (got2_q[i] !== DW'(i)) begin
                    bad++;
                    $display("FAIL clken_order pass%0d idx%0d: got %h want %h", pass, i, got2_q[i], DW'(i));
                end
            end
        end
    endtask

    task automatic test_out_of_range;
        logic [DW-1:0] keep;
        keep = mem_m[999];
        wr1(10'd1000, 32'hFFFFFFFF, 4'hF);
        rd1(10'd1000);
        idle(LAT);
        total++;
        if (s1_readdatavalid !== 1'b1 || s1_readdata !== '0) begin
            bad++;
            $display("FAIL oor_read: got vld=%0b data=%h want vld=1 data=0", s1_readdatavalid, s1_readdata);
        end
        rd1(10'd999);
        idle(LAT);
        total++;
        if (s1_readdata !== keep) begin
            bad++;
            $display("FAIL oor_neighbour: got %h want %h", s1_readdata, keep);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_read;
        wr1(4, 32'h77, 4'hF);
        got1_q.delete();
        rd1(4);
        reset_n = 1'b0;
        exp1_q.delete(); due1_q.delete(); exp2_q.delete(); due2_q.delete();
        #1;
        total++;
        if (s1_readdatavalid !== 1'b0 || s1_readdata !== '0 || s2_readdata !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got vld=%0b d1=%h d2=%h want 0 0 0",
                     s1_readdatavalid, s1_readdata, s2_readdata);
        end
        idle(2);
        reset_n = 1'b1;
        idle(LAT + 2);
        total++;
        if (got1_q.size() != 0) begin
            bad++;
            $display("FAIL reset_mid_dropped: got %0d pulses want 0", got1_q.size());
        end
        rd1(4);
        idle(LAT);
        total++;
        if (s1_readdatavalid !== 1'b1 || s1_readdata !== 32'h77) begin
            bad++;
            $display("FAIL reset_mid_retained: got vld=%0b data=%h want vld=1 data=00000077",
                     s1_readdatavalid, s1_readdata);
        end
        idle(2);
    endtask

    task automatic test_random;
        logic [AW-1:0] a1, a2;
        for (int n = 0; n < 600; n++) begin
            a1 = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(1000, 1023)) : AW'($urandom_range(0, 15));
            a2 = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(1000, 1023)) : AW'($urandom_range(0, 15));
            drive($urandom_range(0, 99) < 85,
                  $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), a1, 4'($urandom), $urandom,
                  $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), a2, 4'($urandom), $urandom);
        end
        idle(LAT + 2);
        total++;
        if (exp1_q.size() != 0 || exp2_q.size() != 0) begin
            bad++;
            $display("FAIL random_drain: got pending s1=%0d s2=%0d want 0 0", exp1_q.size(), exp2_q.size());
        end
    endtask

    initial begin
        reset_n = 1'b1;
        clken = 1'b1;
        s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
        s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
        #2 reset_n = 1'b0;
        test_reset();
        test_preload();
        test_byte_mask();
        test_collision();
        test_cross_rdw();
        test_clken();
        test_out_of_range();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/onchip_ram_dualport.md
# onchip_ram_dualport

Parametrised dual-port on-chip RAM with two independent Avalon-MM slave ports, s1 and s2, sharing one clock. It is the successor to the single-port on-chip memory. It adds a second port, configurable width and depth, a pipelined read path with `readdatavalid`, an optional output register, and defined rules for write collisions and out-of-range addresses. It sits on the Nios system interconnect as program/data memory, or as a shared buffer between the CPU and a DMA master.

## Interface
- `DATA_W`, 32: data width per word; must be a multiple of 8.
- `DEPTH`, 32000: number of words.
- `ADDR_W`, 15: word-address width; must satisfy 2**ADDR_W >= DEPTH.
- `OUT_REG`, 0: 0 gives read latency 1; 1 adds an output register, giving read latency 2.
- `BE_W`, DATA_W/8: byteenable width (derived, not overridden).
- `clk` in 1: single clock for both ports.
- `reset_n` in 1: asynchronous, active-low reset.
- `clken` in 1: global clock enable; low stalls both ports.
- `s1_address` / `s2_address` in ADDR_W: word address.
- `s1_chipselect` / `s2_chipselect` in 1: port select.
- `s1_read` / `s2_read` in 1: read request.
- `s1_write` / `s2_write` in 1: write request.
- `s1_byteenable` / `s2_byteenable` in BE_W: per-byte write enable.
- `s1_writedata` / `s2_writedata` in DATA_W: write data.
- `s1_readdata` / `s2_readdata` out DATA_W: read data.
- `s1_readdatavalid` / `s2_readdatavalid` out 1: one-cycle pulse marking valid `readdata`.

## Operation
- **Accept:** a port accepts a request on a rising edge of `clk` when `chipselect & clken` is high. There is no waitrequest; each port takes one request per cycle.
- **Read and write together:** if `read` and `write` are both high on one port, the write executes and the read is discarded.
- **Write:** each byte i of mem[address] is updated iff `byteenable[i]` is high. Other bytes are untouched.
- **Same-address double write:** if both ports write the same address in the same cycle, s1 wins on every byte both ports enable. Bytes enabled only by s2 take s2 data.
- **Out of range (address >= DEPTH):** writes are dropped. Reads return 0 and still produce `readdatavalid`.
- **Cross-port read-during-write:** port X reads the address that port Y writes in the same cycle. The read returns the old word (see Configuration).
- **Same-port read-after-write:** a read on the cycle after a write to the same address returns the new data.
- **Reset:** memory contents are not cleared by `reset_n`. Contents are undefined at power-up.
- **Reset values:** `readdata` = 0 and `readdatavalid` = 0 on both ports. Read pipeline valid bits are cleared. Reads in flight when `reset_n` asserts are dropped, with no `readdatavalid`.
- **clken low:**
  - no request is accepted and the memory is not written;
  - pipeline registers hold their contents;
  - `readdatavalid` is forced to 0;
  - the held result is delivered exactly once after `clken` returns high.

## Timing
- Read accepted at edge T:
  - OUT_REG=0: `readdata` is valid and `readdatavalid` is high in the cycle following edge T+1, i.e. visible after edge T+1.
  - OUT_REG=1: both appear one edge later, after edge T+2.
- Back-to-back reads give one `readdatavalid` per cycle, in request order, per port.
- `readdata` holds its last value when `readdatavalid` is low. Checkers compare only while it is high.
- A write lands at edge T and is visible to any read accepted at edge T+1 or later.
- Ports are fully independent in timing; there is no arbitration stall.

## Configuration
- `ONCHIP_RAM_BYPASS_EN`:
  - **Defined:** on a cross-port same-address read-during-write, the read returns the merged new word. The merge uses the writer's enabled bytes, with s1 winning per byte if both write. Latency is unchanged. This forwarding logic lives in the read pipeline.
  - **Undefined:** the read returns the old word, and no forwarding logic is built.

## Structure
- Package `onchip_ram_pkg` holds:
  - default constants `ONCHIP_RAM_DATA_W_DEF`, `ONCHIP_RAM_DEPTH_DEF`;
  - function `be_merge(old, new, be)` for byte-lane merging;
  - typedef `rd_req_t` = {valid, addr_oor}.
- Memory array is a behavioural reg array inferred as true dual-port block RAM.
- Sub-module `onchip_ram_rdpipe`, instantiated once per port, contains:
  - request valid tracking;
  - the optional OUT_REG stage;
  - `clken` hold;
  - out-of-range zeroing;
  - the bypass mux under the macro.

## Test plan
- **Byte-masked write:** s1 writes 0xDEADBEEF to addr 5 with be=4'b1111, then s1 writes 0x00000011 with be=4'b0001, then s1 reads addr 5. Expect `readdata` 0xDEADBE11 with `readdatavalid` one cycle after accept (OUT_REG=0), and two cycles after accept (OUT_REG=1).
- **Same-address collision:** in the same cycle, s1 writes 0xAAAAAAAA with be=4'b0011 and s2 writes 0x55555555 with be=4'b0110, both to addr 9 previously holding 0. A later read of addr 9 returns 0x0055AAAA.
- **Cross-port read-during-write:** addr 3 = 0x1; s1 writes 0x2 to addr 3 while s2 reads addr 3. Expect s2 `readdata` 0x1 without the macro, and 0x2 with `ONCHIP_RAM_BYPASS_EN`.
- **Pipelined reads with clken:** 8 back-to-back s2 reads of addrs 0..7 preloaded with the value i. Expect 8 consecutive `readdatavalid` pulses with data 0..7. Repeat with `clken` low for 3 cycles mid-stream: no duplicate and no lost pulse, and order is preserved.
- **Out of range:** DEPTH=1000; s1 writes 0xFFFFFFFF to addr 1000, then reads addr 1000. Expect `readdata` 0 with `readdatavalid`. addr 999 is unchanged.
- **Reset mid-read:** issue a read of addr 4 (holding 0x77), then pulse `reset_n` low before the result is delivered. No `readdatavalid` for the dropped read and outputs are 0. A post-reset read of addr 4 still returns 0x77.
